// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Pops single-byte ASCII commands from the uart receive FIFO and decodes
//   them into stopwatch controls. 'G' starts the stopwatch, 'P' pauses it
//   and 'C' clears it (letters are matched in either case). 'R' snapshots
//   the BCD digits and streams them back as ASCII followed by CR LF. Any
//   other byte is answered with "?" CR LF.
//
// Ports
//   clk, rst_n   single clock, asynchronous active-low reset
//   rx_empty     receive FIFO empty
//   rd_data      receive FIFO head byte (valid while rx_empty = 0)
//   rd_uart      receive FIFO pop (asserted only in IDLE)
//   tx_full      transmit FIFO full
//   wr_uart      transmit FIFO push (asserted only in SEND)
//   wr_data      byte being pushed
//   bcd_in       stopwatch digits, most significant digit in the top nibble
//   run          stopwatch enable level (registered)
//   clr          stopwatch clear, one-cycle pulse (registered)
//   busy         high whenever the FSM is not in IDLE
module uart_cmd_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_empty,
    input  logic [7:0]          rd_data,
    output logic                rd_uart,
    input  logic                tx_full,
    output logic                wr_uart,
    output logic [7:0]          wr_data,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                run,
    output logic                clr,
    output logic                busy
);

    localparam int               IDX_W    = $clog2(DIGITS + 3);
    localparam logic [IDX_W-1:0] LAST_RPT = IDX_W'(DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_ERR = IDX_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        SEND
    } state_t;

    state_t              state;
    logic [7:0]          cmd;
    logic [4*DIGITS-1:0] snap;
    logic                err_msg;
    logic [IDX_W-1:0]    idx;

    logic [7:0]          cmd_uc;
    logic [3:0]          nib;
    logic                last_byte;

    // Clearing bit 5 folds lower-case ASCII letters onto upper case.
    assign cmd_uc    = cmd & 8'hDF;
    assign busy      = (state != IDLE);

    // The strobes are decoded from state, so they are gated with rst_n to
    // stay low for the whole time reset is asserted.
    assign rd_uart   = rst_n && (state == IDLE) && !rx_empty;
    assign wr_uart   = rst_n && (state == SEND) && !tx_full;
    assign last_byte = (idx == (err_msg ? LAST_ERR : LAST_RPT));

    // Byte index i selects snapshot digit i counted from the most
    // significant end.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib = snap[4*(DIGITS-1-i) +: 4];
            end
        end
    end

    always_comb begin
        wr_data = 8'h00;
        if (state == SEND) begin
            if (err_msg) begin
                if (idx == '0)                     wr_data = 8'h3F;
                else if (idx == IDX_W'(1))         wr_data = 8'h0D;
                else                               wr_data = 8'h0A;
            end else begin
                if (idx < IDX_W'(DIGITS))          wr_data = (nib > 4'd9) ? 8'h3F : {4'h3, nib};
                else if (idx == IDX_W'(DIGITS))    wr_data = 8'h0D;
                else                               wr_data = 8'h0A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmd     <= 8'h00;
            // NOTE: the snapshot is an ordinary register bank, not a RAM, so
            // it is reset along with the rest of the state.
            snap    <= '0;
            err_msg <= 1'b0;
            idx     <= '0;
            run     <= 1'b0;
            clr     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register sees the pre-edge values of the others.
            clr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        cmd   <= rd_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    idx     <= '0;
                    err_msg <= 1'b0;
                    state   <= IDLE;
                    case (cmd_uc)
                        8'h47: run <= 1'b1;
                        8'h50: run <= 1'b0;
                        8'h43: clr <= 1'b1;
                        8'h52: begin
                            snap  <= bcd_in;
                            state <= SEND;
                        end
                        default: begin
                            err_msg <= 1'b1;
                            state   <= SEND;
                        end
                    endcase
                end
                SEND: begin
                    // A full transmit FIFO simply holds index and byte.
                    if (!tx_full) begin
                        if (last_byte) state <= IDLE;
                        else           idx   <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl (DIGITS = 4).
// A queue models the receive FIFO; expected transmit bytes go into a
// scoreboard queue when a command is issued and a monitor pops and compares
// them whenever the DUT pushes a byte. Inputs change on the falling edge;
// the bench samples at +3 and the monitor at +4 after it, both well before
// the rising edge.
module tb_uart_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx_empty;
    logic [7:0]  rd_data;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  wr_data;
    logic [15:0] bcd_in;
    logic        run;
    logic        clr;
    logic        busy;

    uart_cmd_ctrl #(.DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_empty (rx_empty),
        .rd_data  (rd_data),
        .rd_uart  (rd_uart),
        .tx_full  (tx_full),
        .wr_uart  (wr_uart),
        .wr_data  (wr_data),
        .bcd_in   (bcd_in),
        .run      (run),
        .clr      (clr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         rd_cnt      = 0;
    int         wr_cnt      = 0;
    logic       pop_pending = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [8:0] exp_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push an n-byte message (first byte in the most significant position).
    task automatic expect_msg(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic push_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_q.push_back(b);
    endtask

    task automatic smp();
        @(negedge clk);
        #3;
    endtask

    // Receive FIFO model: pop what the DUT took last edge, then present head.
    always begin
        @(negedge clk);
        if (pop_pending) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            pop_pending = 1'b0;
        end
        #1;
        rx_empty = (rx_q.size() == 0);
        rd_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    // Monitor: values seen here are the ones the DUT acts on at the next edge.
    always begin
        @(negedge clk);
        #4;
        if (rd_uart) begin
            pop_pending = 1'b1;
            rd_cnt++;
        end
        if (wr_uart) begin
            wr_cnt++;
            exp_b = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            check("tx_byte", 32'({1'b0, wr_data}), 32'(exp_b));
            check("wr_while_full", 32'(tx_full), 0);
            check("rd_wr_excl", 32'(rd_uart), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int r0;
    int w0;

    initial begin
        rst_n    = 1'b0;
        tx_full  = 1'b0;
        bcd_in   = 16'h0000;
        rx_empty = 1'b1;
        rd_data  = 8'h00;

        // Reset state
        #3;
        check("rst_run",     32'(run),     0);
        check("rst_clr",     32'(clr),     0);
        check("rst_busy",    32'(busy),    0);
        check("rst_rd_uart", 32'(rd_uart), 0);
        check("rst_wr_uart", 32'(wr_uart), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 'G': one pop, one busy cycle, run two edges later
        r0 = rd_cnt;
        push_cmd(8'h47);
        smp();
        check("g_busy_decode", 32'(busy), 1);
        check("g_run_early",   32'(run),  0);
        smp();
        check("g_busy_done",   32'(busy), 0);
        check("g_run",         32'(run),  1);
        check("g_pop_count",   32'(rd_cnt - r0), 1);

        // 'p' (lower case pause)
        push_cmd(8'h70);
        smp();
        smp();
        check("p_run", 32'(run), 0);

        // 'g' restarts, then 'C' pulses clr without touching run
        push_cmd(8'h67);
        smp();
        smp();
        check("g2_run", 32'(run), 1);
        w0 = wr_cnt;
        push_cmd(8'h43);
        smp();
        check("c_clr_early", 32'(clr),  0);
        check("c_busy",      32'(busy), 1);
        smp();
        check("c_clr_pulse", 32'(clr),  1);
        check("c_run_kept",  32'(run),  1);
        smp();
        check("c_clr_end",   32'(clr),  0);
        check("c_run_kept2", 32'(run),  1);
        check("c_no_tx",     32'(wr_cnt - w0), 0);

        // 'R' with bcd 0x1234; bcd changes mid-message
        bcd_in = 16'h1234;
        expect_msg(64'h3132_3334_0D0A, 6);
        push_cmd(8'h52);
        smp();
        check("r_decode_no_wr", 32'(wr_uart), 0);
        for (int m = 2; m <= 7; m++) begin
            @(negedge clk);
            if (m == 4) bcd_in = 16'h9999;
            #3;
            check("r_wr_consec", 32'(wr_uart), 1);
        end
        smp();
        check("r_idle_after", 32'(busy), 0);
        check("r_drained",    32'(exp_q.size()), 0);

        // 'R' with tx_full high for 3 cycles after the second byte
        bcd_in = 16'h1234;
        expect_msg(64'h3132_3334_0D0A, 6);
        push_cmd(8'h52);
        smp();
        for (int m = 2; m <= 10; m++) begin
            @(negedge clk);
            tx_full = (m >= 4 && m <= 6);
            #3;
            check("stall_wr", 32'(wr_uart), 32'(!tx_full));
            if (tx_full) check("stall_hold_data", 32'(wr_data), 32'h33);
        end
        tx_full = 1'b0;
        smp();
        check("stall_idle_after", 32'(busy), 0);
        check("stall_drained",    32'(exp_q.size()), 0);

        // Unknown 'x' then 'R' with a non-decimal nibble
        bcd_in = 16'h1A00;
        expect_msg(64'h3F_0D0A, 3);
        expect_msg(64'h313F_3030_0D0A, 6);
        @(negedge clk);
        rx_q.push_back(8'h78);
        rx_q.push_back(8'h52);
        for (int n = 0; n < 40; n++) begin
            smp();
            if (exp_q.size() == 0) break;
        end
        check("err_drained",   32'(exp_q.size()), 0);
        check("err_idle_after", 32'(busy), 0);

        // 'R' and 'G' queued; reset after the second reply byte
        bcd_in = 16'h1234;
        expect_msg(64'h3132_3334_0D0A, 6);
        w0 = wr_cnt;
        @(negedge clk);
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h47);
        smp();
        smp();
        smp();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_wr_uart", 32'(wr_uart), 0);
        check("mid_rst_rd_uart", 32'(rd_uart), 0);
        check("mid_rst_wr_data", 32'(wr_data), 0);
        check("mid_rst_run",     32'(run),     0);
        check("mid_rst_clr",     32'(clr),     0);
        check("mid_rst_busy",    32'(busy),    0);
        check("mid_rst_bytes",   32'(wr_cnt - w0), 2);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("post_rst_pop", 32'(rd_uart), 1);
        smp();
        check("post_rst_busy", 32'(busy), 1);
        smp();
        check("post_rst_run",  32'(run),  1);
        check("post_rst_idle", 32'(busy), 0);

        smp();
        smp();
        check("final_no_tx_left", 32'(exp_q.size()), 0);
        check("final_rx_empty",   32'(rx_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
